// File: rtl/alu_div_arbiter.sv
// rtl/alu_div_arbiter.sv - round-robin arbiter sharing one divider between two ports
// Handles divide-by-zero locally and aborts a divider that never reports done.
module alu_div_arbiter #(
   parameter int WIDTH   = 3,
   parameter int TIMEOUT = 31
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic [WIDTH-1:0]   md0,
   input  logic [WIDTH-1:0]   mr0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   md1,
   input  logic [WIDTH-1:0]   mr1,
   output logic               ack0,
   output logic               ack1,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic               busy,
   output logic               div_init,
   output logic [WIDTH-1:0]   div_md,
   output logic [WIDTH-1:0]   div_mr,
   input  logic               div_done,
   input  logic [2*WIDTH-1:0] div_result
);

   localparam int CW = 5;

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_LAUNCH, S_WAIT, S_RESP, S_DZERO
   } state_t;

   state_t             state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_q, last_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   md_q, md_d;
   logic [WIDTH-1:0]   mr_q, mr_d;

   logic               owner_req;
   logic [WIDTH-1:0]   owner_md;
   logic [WIDTH-1:0]   owner_mr;

   assign owner_req = owner_q ? req1 : req0;
   assign owner_md  = owner_q ? md1  : md0;
   assign owner_mr  = owner_q ? mr1  : mr0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         md_q     <= '0;
         mr_q     <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
         md_q     <= md_d;
         mr_q     <= mr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
      md_d     = md_q;
      mr_d     = mr_q;
      div_init = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_GRANT;
               // On a tie the port that was not served last goes first.
               owner_d = (req0 && req1) ? ~last_q : req1;
            end
         end
         S_GRANT: begin
            md_d    = owner_md;
            mr_d    = owner_mr;
            state_d = (owner_mr == '0) ? S_DZERO : S_LAUNCH;
         end
         S_LAUNCH: begin
            div_init = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (div_done) begin
               result_d = div_result;
               err_d    = 1'b0;
               state_d  = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_DZERO: begin
            result_d = {md_q, {WIDTH{1'b1}}};
            err_d    = 1'b1;
            state_d  = S_RESP;
         end
         S_RESP: begin
            // A dropped request still counts as served for fairness.
            last_d  = owner_q;
            ack0    = owner_req && !owner_q;
            ack1    = owner_req && owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign result = result_q;
   assign err    = err_q;
   assign div_md = md_q;
   assign div_mr = mr_q;

endmodule

// File: tb/tb_alu_div_arbiter.sv
// tb/tb_alu_div_arbiter.sv - directed self-checking bench for alu_div_arbiter
module tb_alu_div_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [2:0] md0 = '0, mr0 = '0, md1 = '0, mr1 = '0;
   logic       ack0, ack1, err, busy, div_init;
   logic [5:0] result;
   logic [2:0] div_md, div_mr;
   logic       div_done;
   logic [5:0] div_result = '0;

   int errors = 0;
   int checks = 0;
   int init_cnt = 0;
   int both_ack = 0;
   int div_delay = 8;
   int dcnt = 0;

   alu_div_arbiter #(.WIDTH(3), .TIMEOUT(31)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .md0(md0), .mr0(mr0),
      .req1(req1), .md1(md1), .mr1(mr1),
      .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
      .div_init(div_init), .div_md(div_md), .div_mr(div_mr),
      .div_done(div_done), .div_result(div_result)
   );

   always #5 clk = ~clk;

   // Divider model: done pulses in the div_delay-th WAIT cycle; 0 means never.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dcnt <= 0;
      end else if (div_init) begin
         dcnt <= div_delay;
         div_result <= {div_md % div_mr, div_md / div_mr};
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
      end
   end
   assign div_done = (dcnt == 1);

   always @(posedge clk) begin
      if (div_init) init_cnt++;
      if (ack0 && ack1) both_ack++;
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic wait_ack(input bit port, output int n, output bit other);
      n = -1;
      other = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (port ? ack0 : ack1) other = 1'b1;
         if (port ? ack1 : ack0) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({ack0, ack1, err, div_init} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {ack0, ack1, err, div_init}); end
      checks++; if (result !== 6'd0) begin errors++; $display("FAIL reset_result got=%b exp=000000", result); end
      checks++; if ({div_md, div_mr} !== 6'd0) begin errors++; $display("FAIL reset_divops got=%b exp=000000", {div_md, div_mr}); end
   endtask

   task automatic test_single();
      int n;
      bit other;
      init_cnt = 0; div_delay = 8;
      md0 = 3'd7; mr0 = 3'd2; req0 = 1'b1;
      wait_ack(1'b0, n, other);
      checks++; if (n !== 11) begin errors++; $display("FAIL single_latency got=%0d exp=11", n); end
      checks++; if (result !== 6'b001_011) begin errors++; $display("FAIL single_result got=%b exp=001011", result); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err); end
      checks++; if ({div_md, div_mr} !== {3'd7, 3'd2}) begin errors++; $display("FAIL single_divops got=%b exp=111010", {div_md, div_mr}); end
      checks++; if (other !== 1'b0) begin errors++; $display("FAIL single_ack1 got=%b exp=0", other); end
      @(posedge clk); #1 req0 = 1'b0;
      checks++; if (init_cnt !== 1) begin errors++; $display("FAIL single_init_pulses got=%0d exp=1", init_cnt); end
      checks++; if (result !== 6'b001_011) begin errors++; $display("FAIL single_hold got=%b exp=001011", result); end
   endtask

   task automatic test_round_robin();
      int n;
      bit other;
      apply_reset();
      div_delay = 8;
      md0 = 3'd6; mr0 = 3'd3; md1 = 3'd5; mr1 = 3'd2;
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(1'b0, n, other);
      checks++; if (n !== 11) begin errors++; $display("FAIL rr1_port0_latency got=%0d exp=11", n); end
      checks++; if (result !== 6'b000_010) begin errors++; $display("FAIL rr1_port0_result got=%b exp=000010", result); end
      @(posedge clk); #1 req0 = 1'b0;
      wait_ack(1'b1, n, other);
      checks++; if (n !== 11 || other !== 1'b0) begin errors++; $display("FAIL rr1_port1 got=%0d/%b exp=11/0", n, other); end
      checks++; if (result !== 6'b001_010) begin errors++; $display("FAIL rr1_port1_result got=%b exp=001010", result); end
      @(posedge clk); #1 req1 = 1'b0;
      // Port 0 alone once more, leaving port 0 as last served.
      req0 = 1'b1;
      wait_ack(1'b0, n, other);
      @(posedge clk); #1 req0 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(1'b1, n, other);
      checks++; if (n !== 11 || other !== 1'b0) begin errors++; $display("FAIL rr2_port1_first got=%0d/%b exp=11/0", n, other); end
      checks++; if (result !== 6'b001_010) begin errors++; $display("FAIL rr2_port1_result got=%b exp=001010", result); end
      @(posedge clk); #1 req1 = 1'b0;
      wait_ack(1'b0, n, other);
      checks++; if (result !== 6'b000_010 || n !== 11) begin errors++; $display("FAIL rr2_port0 got=%b/%0d exp=000010/11", result, n); end
      @(posedge clk); #1 req0 = 1'b0;
   endtask

   task automatic test_dzero();
      int n;
      bit other;
      init_cnt = 0;
      md1 = 3'd5; mr1 = 3'd0; req1 = 1'b1;
      wait_ack(1'b1, n, other);
      checks++; if (n !== 3) begin errors++; $display("FAIL dzero_latency got=%0d exp=3", n); end
      checks++; if (result !== 6'b101_111) begin errors++; $display("FAIL dzero_result got=%b exp=101111", result); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL dzero_err got=%b exp=1", err); end
      @(posedge clk); #1 req1 = 1'b0;
      checks++; if (init_cnt !== 0) begin errors++; $display("FAIL dzero_init got=%0d exp=0", init_cnt); end
   endtask

   task automatic test_timeout();
      int n;
      bit other;
      div_delay = 0;
      md0 = 3'd3; mr0 = 3'd1; req0 = 1'b1;
      wait_ack(1'b0, n, other);
      checks++; if (n !== 34) begin errors++; $display("FAIL timeout_latency got=%0d exp=34", n); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", err); end
      checks++; if (result !== 6'd0) begin errors++; $display("FAIL timeout_result got=%b exp=000000", result); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_resp got=%b exp=1", busy); end
      @(posedge clk); #1 req0 = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got=%b exp=0", busy); end
      div_delay = 8;
   endtask

   task automatic test_reset_mid();
      int n;
      bit other;
      md0 = 3'd7; mr0 = 3'd2; req0 = 1'b1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if ({div_init, ack0, ack1} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b exp=000", {div_init, ack0, ack1}); end
      req0 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      req0 = 1'b1;
      wait_ack(1'b0, n, other);
      checks++; if (n !== 11 || result !== 6'b001_011) begin errors++; $display("FAIL rstmid_fresh got=%0d/%b exp=11/001011", n, result); end
      @(posedge clk); #1 req0 = 1'b0;
   endtask

   task automatic test_drop();
      int n;
      bit other;
      md0 = 3'd6; mr0 = 3'd3; req0 = 1'b1;
      repeat (5) @(posedge clk);
      #1 req0 = 1'b0;
      md1 = 3'd5; mr1 = 3'd2; req1 = 1'b1;
      wait_ack(1'b1, n, other);
      checks++; if (n !== 18) begin errors++; $display("FAIL drop_port1_latency got=%0d exp=18", n); end
      checks++; if (other !== 1'b0) begin errors++; $display("FAIL drop_ack0 got=%b exp=0", other); end
      checks++; if (result !== 6'b001_010) begin errors++; $display("FAIL drop_result got=%b exp=001010", result); end
      @(posedge clk); #1 req1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_dzero();
      test_timeout();
      test_reset_mid();
      test_drop();
      checks++; if (both_ack !== 0) begin errors++; $display("FAIL ack_overlap got=%0d exp=0", both_ack); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
